// File: rtl/multicycle_controller.sv
// multicycle_controller: multicycle RISC-V style control FSM with a memory handshake.
// Ports: clk/rst_n (async active-low); opcode/funct3/funct7b5 from the instruction register;
// zero_flag/sign_flag from the live ALU result; mem_ready completes memory accesses.
// Outputs: datapath enables/selects, illegal (sticky), state (debug).
module multicycle_controller #(
    parameter int ENABLE_JAL   = 1,
    parameter int ENABLE_BLT   = 1,
    parameter int ILLEGAL_HALT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero_flag,
    input  logic       sign_flag,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       adr_src,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
    output logic       illegal,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BRANCH, JAL, HALT
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    state_t cur;
    logic   op_mem, op_legal, br_taken;
    logic [2:0] alu_dec;

    assign state    = cur;
    assign op_mem   = opcode == OP_LW || opcode == OP_SW;
    assign op_legal = op_mem || opcode == OP_R || opcode == OP_I || opcode == OP_B ||
                      (opcode == OP_JAL && ENABLE_JAL != 0);
    assign imm_src  = opcode == OP_SW ? 2'b01 : opcode == OP_B ? 2'b10 :
                      opcode == OP_JAL ? 2'b11 : 2'b00;
    // Only register-register forms (opcode[5]) may select sub; slt/sltu are not supported and fall back to add.
    assign alu_dec  = funct3 == 3'b000 ? ((opcode[5] && funct7b5) ? 3'b010 : 3'b000) :
                      (funct3 == 3'b010 || funct3 == 3'b011) ? 3'b000 : funct3;
    assign br_taken = funct3 == 3'b000 ? zero_flag :
                      funct3 == 3'b001 ? ~zero_flag :
                      (funct3 == 3'b100 && ENABLE_BLT != 0) ? sign_flag : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur     <= FETCH;
            illegal <= 1'b0;
        end else begin
            unique case (cur)
                FETCH:    cur <= mem_ready ? DECODE : FETCH;
                DECODE:   if (op_legal)
                              cur <= op_mem ? MEMADR : opcode == OP_R ? EXECR :
                                     opcode == OP_I ? EXECI : opcode == OP_B ? BRANCH : JAL;
                          else begin
                              illegal <= 1'b1;
                              cur     <= ILLEGAL_HALT != 0 ? HALT : FETCH;
                          end
                MEMADR:   cur <= opcode == OP_LW ? MEMREAD : MEMWRITE;
                MEMREAD:  cur <= mem_ready ? MEMWB : MEMREAD;
                MEMWRITE: cur <= mem_ready ? FETCH : MEMWRITE;
                EXECR, EXECI, JAL: cur <= ALUWB;
                HALT:     cur <= HALT;
                default:  cur <= FETCH;
            endcase
        end
    end

    // Moore decode; the reset term keeps fetch enables low while rst_n is held.
    always_comb begin
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        mem_write   = 1'b0;
        adr_src     = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = 3'b000;
        unique case (cur)
            FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready & rst_n;
                pc_write   = mem_ready & rst_n;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            MEMREAD:  adr_src = 1'b1;
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            EXECR: begin
                alu_src_a   = 2'b10;
                alu_control = alu_dec;
            end
            EXECI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = alu_dec;
            end
            ALUWB:    reg_write = 1'b1;
            BRANCH: begin
                alu_src_a   = 2'b10;
                alu_control = 3'b010;
                pc_write    = br_taken;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed plus random instruction streams checked against a per-instruction reference.
module tb_multicycle_controller;
    localparam int EN_BLT = 0;
    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RR = 7'b0110011;
    localparam logic [6:0] II = 7'b0010011, BB = 7'b1100011, JJ = 7'b1101111;
    localparam logic [3:0] S_F = 0, S_D = 1, S_MA = 2, S_MR = 3, S_MWB = 4, S_MW = 5;
    localparam logic [3:0] S_ER = 6, S_EI = 7, S_AW = 8, S_BR = 9, S_J = 10, S_H = 11;

    typedef struct packed {
        logic [3:0] st;
        logic       pc, ir, rw, mw, adr;
        logic [1:0] rs, sa, sb;
        logic [2:0] alu;
        logic [1:0] imm;
        logic       ill;
    } exp_t;

    logic clk = 0, rst_n = 0;
    logic [6:0] opcode = RR;
    logic [2:0] funct3 = 0;
    logic funct7b5 = 0, zero_flag = 0, sign_flag = 0, mem_ready = 1;
    logic pc_write, ir_write, reg_write, mem_write, adr_src, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
    logic [3:0] state;
    logic ill_exp = 0;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.ENABLE_JAL(1), .ENABLE_BLT(EN_BLT), .ILLEGAL_HALT(1)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .zero_flag(zero_flag), .sign_flag(sign_flag), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write), .mem_write(mem_write),
        .adr_src(adr_src), .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .imm_src(imm_src), .alu_control(alu_control), .illegal(illegal), .state(state)
    );

    function automatic logic [1:0] imm_ref(logic [6:0] op);
        return op == SW ? 2'd1 : op == BB ? 2'd2 : op == JJ ? 2'd3 : 2'd0;
    endfunction

    function automatic logic [2:0] alu_ref(logic [6:0] op, logic [2:0] f3, logic f7);
        if (f3 == 0) return (op == RR && f7) ? 3'd2 : 3'd0;
        if (f3 == 2 || f3 == 3) return 3'd0;
        return f3;
    endfunction

    function automatic logic taken_ref(logic [2:0] f3, logic z, logic s);
        if (f3 == 0) return z;
        if (f3 == 1) return !z;
        if (f3 == 4) return EN_BLT != 0 && s;
        return 1'b0;
    endfunction

    function automatic exp_t blank(logic [3:0] st);
        exp_t e = '0;
        e.st = st;
        e.imm = imm_ref(opcode);
        e.ill = ill_exp;
        return e;
    endfunction

    function automatic exp_t fetch_exp();
        exp_t e = blank(S_F);
        e.sb = 2;
        e.rs = 2;
        e.pc = mem_ready & rst_n;
        e.ir = mem_ready & rst_n;
        return e;
    endfunction

    task automatic chk(input exp_t e, input string tag);
        exp_t g;
        g = {state, pc_write, ir_write, reg_write, mem_write, adr_src, result_src,
             alu_src_a, alu_src_b, alu_control, imm_src, illegal};
        checks++;
        assert (g === e) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, g, e);
        end
    endtask

    task automatic drive(input logic mr);
        mem_ready = mr;
        zero_flag = 1'($urandom % 2);
        sign_flag = 1'($urandom % 2);
    endtask

    task automatic tick(input exp_t e, input string tag);
        #1 chk(e, tag);
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input int waits, input int zf, input int sf, input string tag);
        exp_t e;
        opcode = op; funct3 = f3; funct7b5 = f7;
        for (int i = 0; i <= waits; i++) begin
            drive(i == waits);
            tick(fetch_exp(), {tag, ":fetch"});
        end
        drive(1'($urandom % 2));
        e = blank(S_D); e.sa = 1; e.sb = 1;
        tick(e, {tag, ":decode"});
        if (op == LW || op == SW) begin
            drive(1'($urandom % 2));
            e = blank(S_MA); e.sa = 2; e.sb = 1;
            tick(e, {tag, ":memadr"});
            for (int i = 0; i <= waits; i++) begin
                drive(i == waits);
                e = blank(op == LW ? S_MR : S_MW); e.adr = 1; e.mw = op == SW;
                tick(e, {tag, ":mem"});
            end
            if (op == LW) begin
                drive(1'($urandom % 2));
                e = blank(S_MWB); e.rs = 1; e.rw = 1;
                tick(e, {tag, ":memwb"});
            end
        end else if (op == RR || op == II) begin
            drive(1'($urandom % 2));
            e = blank(op == RR ? S_ER : S_EI); e.sa = 2; e.sb = op == II ? 2'd1 : 2'd0;
            e.alu = alu_ref(op, f3, f7);
            tick(e, {tag, ":exec"});
        end else if (op == BB) begin
            drive(1'($urandom % 2));
            if (zf >= 0) zero_flag = 1'(zf);
            if (sf >= 0) sign_flag = 1'(sf);
            e = blank(S_BR); e.sa = 2; e.alu = 2; e.pc = taken_ref(f3, zero_flag, sign_flag);
            tick(e, {tag, ":branch"});
        end else begin
            drive(1'($urandom % 2));
            e = blank(S_J); e.sa = 1; e.sb = 2; e.pc = 1;
            tick(e, {tag, ":jal"});
        end
        if (op == RR || op == II || op == JJ) begin
            drive(1'($urandom % 2));
            e = blank(S_AW); e.rw = 1;
            tick(e, {tag, ":aluwb"});
        end
    endtask

    // Called mid-cycle with rst_n already low; releases on a falling edge with fetch stalled.
    task automatic release_reset();
        mem_ready = 0;
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        logic [6:0] ops [6];
        ops[0] = LW; ops[1] = SW; ops[2] = RR; ops[3] = II; ops[4] = BB; ops[5] = JJ;
        #1 chk(fetch_exp(), "reset_state");
        release_reset();
        run_instr(RR, 3'b000, 1'b0, 0, -1, -1, "add");
        run_instr(RR, 3'b000, 1'b1, 0, -1, -1, "sub");
        run_instr(II, 3'b000, 1'b1, 0, -1, -1, "addi_f7");
        run_instr(LW, 3'b010, 1'b0, 3, -1, -1, "lw_wait3");
        run_instr(SW, 3'b010, 1'b0, 2, -1, -1, "sw_wait2");
        run_instr(BB, 3'b000, 1'b0, 0, 1, -1, "beq_z1");
        run_instr(BB, 3'b001, 1'b0, 0, 1, -1, "bne_z1");
        run_instr(BB, 3'b100, 1'b0, 0, -1, 1, "blt_s1");
        run_instr(JJ, 3'b000, 1'b0, 0, -1, -1, "jal");
        for (int n = 0; n < 200; n++)
            run_instr(ops[$urandom % 6], 3'($urandom), 1'($urandom % 2), int'($urandom % 3),
                      -1, -1, "rand");
        opcode = 7'b1111111;
        drive(1);
        tick(fetch_exp(), "ill:fetch");
        drive(1);
        e = blank(S_D); e.sa = 1; e.sb = 1;
        tick(e, "ill:decode");
        ill_exp = 1;
        for (int i = 0; i < 10; i++) begin
            drive(1'($urandom % 2));
            tick(blank(S_H), "halt");
        end
        #2 rst_n = 0;
        mem_ready = 1;
        ill_exp = 0;
        #1 chk(fetch_exp(), "halt_async_reset");
        release_reset();
        run_instr(RR, 3'b111, 1'b0, 0, -1, -1, "and_after_halt");
        opcode = SW; funct3 = 3'b010; funct7b5 = 0;
        drive(1);
        tick(fetch_exp(), "swrst:fetch");
        drive(1);
        e = blank(S_D); e.sa = 1; e.sb = 1;
        tick(e, "swrst:decode");
        drive(1);
        e = blank(S_MA); e.sa = 2; e.sb = 1;
        tick(e, "swrst:memadr");
        drive(0);
        e = blank(S_MW); e.adr = 1; e.mw = 1;
        tick(e, "swrst:memwrite");
        #1 chk(e, "swrst:memwrite_held");
        #2 rst_n = 0;
        #1 chk(fetch_exp(), "memwrite_async_reset");
        release_reset();
        run_instr(LW, 3'b010, 1'b0, 1, -1, -1, "lw_after_reset");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter ENABLE_JAL, default 1: 1 = jal (opcode 1101111) decoded; 0 = jal treated as illegal.
REQ-002 Parameter ENABLE_BLT, default 1: 1 = blt (funct3 100) supported; 0 = blt is a never-taken branch.
REQ-003 Parameter ILLEGAL_HALT, default 1: 1 = illegal opcode enters HALT; 0 = illegal opcode returns to FETCH.
REQ-004 clk  in  1  single clock, all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 opcode  in  7  opcode from instruction register, valid from DECODE onward.
REQ-007 funct3  in  3  instruction funct3.
REQ-008 funct7b5  in  1  bit 30 of the instruction.
REQ-009 zero_flag, sign_flag  in  1 each  ALU flags from the current-cycle ALU result.
REQ-010 mem_ready  in  1  memory handshake: access completes in a cycle where it is 1.
REQ-011 pc_write, ir_write, reg_write, mem_write, adr_src  out  1 each  datapath enables/selects.
REQ-012 result_src  out  2  00 ALUOut register, 01 memory read data, 10 live ALU result.
REQ-013 alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1.
REQ-014 alu_src_b  out  2  00 rs2, 01 immediate, 10 constant 4.
REQ-015 imm_src  out  2  00 I, 01 S, 10 B, 11 J, decoded combinationally from opcode in every state.
REQ-016 alu_control  out  3  000 add, 010 sub, 001 sll, 100 xor, 101 srl, 110 or, 111 and.
REQ-017 illegal  out  1  registered; set on illegal opcode in DECODE.
REQ-018 state  out  4  current state encoding, for debug.

Function
REQ-019 States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, HALT. Outputs are Moore on state, except where a requirement gates them on mem_ready, zero_flag or sign_flag.
REQ-020 Unlisted enables are 0, and unlisted selects are 00, in every state.
REQ-021 FETCH: adr_src=0, src_a=00, src_b=10, add, result_src=10; ir_write=pc_write=mem_ready; FETCH->DECODE only when mem_ready=1, else stay.
REQ-022 DECODE: src_a=01, src_b=01, add. Next state by opcode: 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BRANCH, 1101111->JAL (ENABLE_JAL=1), other->HALT, or FETCH if ILLEGAL_HALT=0.
REQ-023 MEMADR: src_a=10, src_b=01, add. Next state MEMREAD if opcode=0000011, else MEMWRITE.
REQ-024 MEMREAD: adr_src=1, result_src=00. Stay until mem_ready=1, then MEMWB.
REQ-025 MEMWB: result_src=01, reg_write=1, ->FETCH.
REQ-026 MEMWRITE: adr_src=1, mem_write=1 held until mem_ready=1, then ->FETCH.
REQ-027 EXECR: src_a=10, src_b=00. EXECI: src_a=10, src_b=01. Both ->ALUWB.
REQ-028 R/I ALU decode: funct3 000 gives sub only when opcode[5]=1 and funct7b5=1, else add. funct3 001/100/101/110/111 map to 001/100/101/110/111; funct3 010/011 give add.
REQ-029 ALUWB: result_src=00, reg_write=1, ->FETCH.
REQ-030 BRANCH: src_a=10, src_b=00, sub, result_src=00.
REQ-031 BRANCH pc_write: beq(000)=zero_flag, bne(001)=~zero_flag, blt(100)=sign_flag if ENABLE_BLT else 0, other funct3=0. Next state FETCH.
REQ-032 JAL: src_a=01, src_b=10, add, result_src=00, pc_write=1, ->ALUWB, which writes OldPC+4 to rd.
REQ-033 HALT: all enables 0, illegal=1, no exit except reset.
REQ-034 illegal is set on the edge leaving DECODE with an illegal opcode. It stays set until reset in both ILLEGAL_HALT modes.
REQ-035 mem_ready is ignored in all states other than FETCH, MEMREAD and MEMWRITE.
REQ-036 Instruction latency with mem_ready tied to 1: lw 5 cycles, sw 4, R/I 4, branch 3, jal 4.

Reset
REQ-037 rst_n=0 forces state=FETCH and illegal=0 immediately, without waiting for a clock edge, from any state including mid-wait in MEMREAD or MEMWRITE.
REQ-038 During reset, mem_write, reg_write and ir_write are 0; pc_write=0 because mem_ready is gated.
REQ-039 The first rising clk edge after rst_n deasserts evaluates FETCH.

Verification
REQ-040 add (0110011, f3=000, f7b5=0), mem_ready=1 -> states FETCH, DECODE, EXECR, ALUWB; alu_control=000; one reg_write pulse.
REQ-041 sub (f7b5=1) in EXECR -> alu_control=010. addi with f7b5=1 in EXECI -> alu_control=000.
REQ-042 lw with mem_ready=0 for 3 cycles in MEMREAD -> MEMREAD held 4 cycles, then MEMWB with result_src=01 and reg_write=1.
REQ-043 Branch coverage in BRANCH:
- beq with zero_flag=1 -> pc_write=1.
- bne with zero_flag=1 -> pc_write=0.
- blt with sign_flag=1 and ENABLE_BLT=0 -> pc_write=0.
REQ-044 opcode 1111111, ILLEGAL_HALT=1 -> HALT and illegal=1, no enables for 10 cycles. Then rst_n low -> FETCH and illegal=0 asynchronously.
REQ-045 rst_n asserted in MEMWRITE while mem_ready=0 -> mem_write drops immediately and state=FETCH.
